pprm_sbox_pipe: RTL and testbench
=================================

Name: pprm_sbox_pipe

Overview:
- Multi-lane, pipelined AES S-box / inverse S-box engine built on the 3-stage PPRM composite-field inverter.
- Generalises the combinational stage chain into a parametrised elastic pipeline:
  - LANES bytes processed per beat.
  - 1 to 3 register cuts.
  - Per-beat encrypt/decrypt mode.
  - valid/ready backpressure.
- Sits between the AES round datapath and the key-schedule/SubBytes consumers.

Parameters:
- LANES, 4, bytes per beat; lane i occupies data bits [8i+7:8i].
- STAGES, 3, number of register cuts (legal 1..3); equals latency in cycles.
- TAG_W, 4, sideband tag width; used only when PPRM_SBOX_PIPE_TAG_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  pipeline accepts the input beat this cycle.
- in_data  input  8*LANES  input bytes.
- in_dec  input  1  0 = forward S-box, 1 = inverse S-box; applies to all lanes of the beat.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the output beat.
- out_data  output  8*LANES  result bytes.
- busy  output  1  any pipeline stage holds a valid beat.
- inflight  output  2  count of valid beats held in the pipeline (0..STAGES).

Behaviour:
- Clock/reset: one clock domain, clk. reset is synchronous and active-high.
- Reset effects (takes effect at the clk edge while reset = 1):
  - All stage valid bits clear; inflight = 0; busy = 0; out_valid = 0; out_data = 0.
  - in_ready = 0 while reset is high.
  - Reset mid-operation discards every in-flight beat; no output is ever produced for those beats.
- Function per lane, with x = input byte:
  - Forward (in_dec = 0): y = Affine(Inv(x)).
  - Inverse (in_dec = 1): y = Inv(InvAffine(x)).
  - Inv is multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, with Inv(0x00) = 0x00.
  - Affine/InvAffine are the FIPS-197 transforms (constants 0x63 / 0x05).
- Internal partitioning:
  - Part 1: isomorphic map to GF((2^4)^2) plus delta computation.
  - Part 2: GF(2^4) inversion.
  - Part 3: GF(2^4) multiplies, inverse map and affine.
- Register cut placement:
  - STAGES = 3: registers after parts 1, 2 and 3.
  - STAGES = 2: registers after part 2 and part 3.
  - STAGES = 1: single register after part 3.
- The output is always registered; there is no combinational input-to-output path.
- Mode (in_dec) and tag are captured with their beat and travel with it through every stage.
- Handshake (elastic pipeline):
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Stage k loads when it is empty or stage k+1 loads (last stage: when out_ready).
  - in_ready = stage-0 load condition, combinational from out_ready through the stage valids.
  - out_data holds stable while out_valid & !out_ready.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid when out_ready is held high.
  - Throughput is 1 beat/cycle.
  - No bubbles are inserted when the pipeline is full and out_ready = 1.
- Full/stalled pipeline: all stages valid and out_ready = 0 gives in_ready = 0.
- Simultaneous input and output transfer on a full pipe: allowed; inflight is unchanged.
- inflight: +1 on input transfer, -1 on output transfer, unchanged on both or neither. It never exceeds STAGES and never wraps.
- in_data/in_dec are ignored when in_valid = 0.
- out_data keeps its last value when out_valid = 0.
- Elaboration: STAGES outside 1..3 is an elaboration error.

Optional Feature:
- Macro: PPRM_SBOX_PIPE_TAG_EN.
- Defined:
  - Adds in_tag (input, TAG_W) and out_tag (output, TAG_W).
  - The tag is captured on input transfer and presented with its beat's out_data.
  - out_tag resets to 0.
- Undefined: tag ports and tag registers are absent; TAG_W is unused. All other behaviour is identical.

Test Plan:
1. Reset, then LANES = 4, STAGES = 3, out_ready = 1; one beat in_data = 0xFF_53_01_00, in_dec = 0 -> exactly 3 cycles later out_valid = 1, out_data = 0x16_ED_7C_63; inflight returns to 0.
2. Same configuration, in_dec = 1, in_data = 0x16_ED_7C_63 -> out_data = 0xFF_53_01_00; then stream all 256 bytes, alternating mode every beat -> every output matches the golden S-box/inverse S-box, one result per cycle, no bubbles.
3. Backpressure: out_ready = 0, push beats until in_ready drops -> exactly 3 accepted, inflight = 3, busy = 1; out_data stable; release out_ready -> 3 beats emerge in order, unchanged.
4. Simultaneous transfer: full pipe with in_valid = 1 and out_ready = 1 for 10 cycles -> inflight stays 3; in_ready = 1 every cycle.
5. Reset mid-stream with 2 beats in flight -> next cycle out_valid = 0, inflight = 0, out_data = 0; the flushed beats never appear after reset releases.
6. Repeat test 1 with STAGES = 1 and STAGES = 2 (latency 1 and 2 cycles); with PPRM_SBOX_PIPE_TAG_EN and tags 0x3 then 0xA on successive beats, the tags emerge aligned with their beats.

Source files
------------

// File: rtl/pprm_sbox_pipe.sv
`timescale 1ns/1ps
// Multi-lane AES S-box / inverse S-box, elastic pipeline; optional tag sideband under PPRM_SBOX_PIPE_TAG_EN.
// Latency STAGES cycles (1..3), one beat per cycle, output always registered.
// Backpressure: stage k loads when empty or when stage k+1 loads; in_ready is the stage-0 load condition.
module pprm_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_dec,
`ifdef PPRM_SBOX_PIPE_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy,
  output logic [1:0]         inflight
);

  localparam int W = 8 * LANES;

  if (STAGES < 1 || STAGES > 3 || TAG_W < 1) begin : g_bad_param
    $error("pprm_sbox_pipe: STAGES must be 1..3 and TAG_W >= 1");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gsq(input logic [7:0] a);
    return gmul(a, a);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] pre(input logic [7:0] x, input logic dec);
    return dec ? (rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05) : x;
  endfunction

  function automatic logic [7:0] post(input logic [7:0] v, input logic dec);
    return dec ? v : (v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63);
  endfunction

  // x^16 is the conjugate of x over GF(2^4); the norm x^17 lands in the GF(2^4) subfield.
  function automatic logic [7:0] frob(input logic [7:0] a);
    return gsq(gsq(gsq(gsq(a))));
  endfunction

  // Subfield inverse: d^14 for d in GF(2^4), 0 maps to 0.
  function automatic logic [7:0] sub_inv(input logic [7:0] d);
    logic [7:0] d2;
    logic [7:0] d4;
    d2 = gsq(d);
    d4 = gsq(d2);
    return gmul(gmul(gsq(d4), d4), d2);
  endfunction

  logic [STAGES-1:0] vld, ld, uv, en;

  always_comb begin
    ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = out_ready || (((~vld) >> k) != '0);
    end
  end

  assign uv        = STAGES'({vld, in_valid});
  assign en        = ld & uv;
  assign in_ready  = ld[0] & ~reset;
  assign out_valid = vld[STAGES-1];
  assign busy      = |vld;
  assign inflight  = 2'($countones(vld));

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld[k] <= uv[k];
      end
    end
  end

  logic [W-1:0] s1_fr, s1_nm, t2_fr, t2_nm, s2_ni, t3_fr, t3_ni, s3_y;
  logic         t2_dec, t3_dec;

  always_comb begin
    s1_fr = '0;
    s1_nm = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_fr[8*i +: 8] = frob(pre(in_data[8*i +: 8], in_dec));
      s1_nm[8*i +: 8] = gmul(pre(in_data[8*i +: 8], in_dec), s1_fr[8*i +: 8]);
    end
  end

  if (STAGES == 3) begin : g_cut1
    logic [W-1:0] r_fr, r_nm;
    logic         r_dec;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_fr  <= '0;
        r_nm  <= '0;
        r_dec <= 1'b0;
      end else if (en[0]) begin
        r_fr  <= s1_fr;
        r_nm  <= s1_nm;
        r_dec <= in_dec;
      end
    end
    assign t2_fr  = r_fr;
    assign t2_nm  = r_nm;
    assign t2_dec = r_dec;
  end else begin : g_nocut1
    assign t2_fr  = s1_fr;
    assign t2_nm  = s1_nm;
    assign t2_dec = in_dec;
  end

  always_comb begin
    s2_ni = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_ni[8*i +: 8] = sub_inv(t2_nm[8*i +: 8]);
    end
  end

  if (STAGES >= 2) begin : g_cut2
    logic [W-1:0] r_fr, r_ni;
    logic         r_dec;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_fr  <= '0;
        r_ni  <= '0;
        r_dec <= 1'b0;
      end else if (en[STAGES-2]) begin
        r_fr  <= t2_fr;
        r_ni  <= s2_ni;
        r_dec <= t2_dec;
      end
    end
    assign t3_fr  = r_fr;
    assign t3_ni  = r_ni;
    assign t3_dec = r_dec;
  end else begin : g_nocut2
    assign t3_fr  = t2_fr;
    assign t3_ni  = s2_ni;
    assign t3_dec = t2_dec;
  end

  // x^-1 = x^16 * (x^17)^-1
  always_comb begin
    s3_y = '0;
    for (int i = 0; i < LANES; i++) begin
      s3_y[8*i +: 8] = post(gmul(t3_ni[8*i +: 8], t3_fr[8*i +: 8]), t3_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (en[STAGES-1]) begin
      out_data <= s3_y;
    end
  end

`ifdef PPRM_SBOX_PIPE_TAG_EN
  logic [TAG_W-1:0] tg [STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) tg[k] <= '0;
    end else begin
      if (en[0]) tg[0] <= in_tag;
      for (int k = 1; k < STAGES; k++) begin
        if (en[k]) tg[k] <= tg[k-1];
      end
    end
  end
  assign out_tag = tg[STAGES-1];
`endif

endmodule

// File: tb/tb_pprm_sbox_pipe.sv
`timescale 1ns/1ps
// Randomized bench for pprm_sbox_pipe against a table-driven S-box model (brute-force inverse).
module tb_pprm_sbox_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_dec, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [1:0]  inflight;
  logic        r1_in_ready, r1_out_valid, r1_busy;
  logic [31:0] r1_out_data;
  logic [1:0]  r1_inflight;
  logic        r2_in_ready, r2_out_valid, r2_busy;
  logic [31:0] r2_out_data;
  logic [1:0]  r2_inflight;
`ifdef PPRM_SBOX_PIPE_TAG_EN
  logic [3:0]  in_tag, out_tag, r1_out_tag, r2_out_tag;
`endif

  pprm_sbox_pipe #(.LANES(4), .STAGES(3), .TAG_W(4)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dec(in_dec),
`ifdef PPRM_SBOX_PIPE_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .inflight(inflight));

  pprm_sbox_pipe #(.LANES(4), .STAGES(1), .TAG_W(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_data(in_data), .in_dec(in_dec),
`ifdef PPRM_SBOX_PIPE_TAG_EN
    .in_tag(in_tag), .out_tag(r1_out_tag),
`endif
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
    .busy(r1_busy), .inflight(r1_inflight));

  pprm_sbox_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r2_in_ready),
    .in_data(in_data), .in_dec(in_dec),
`ifdef PPRM_SBOX_PIPE_TAG_EN
    .in_tag(in_tag), .out_tag(r2_out_tag),
`endif
    .out_valid(r2_out_valid), .out_ready(out_ready), .out_data(r2_out_data),
    .busy(r2_busy), .inflight(r2_inflight));

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = int'(a);
    int y = int'(b);
    while (y != 0) begin
      if ((y & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 283;
      y = y >> 1;
    end
    return 8'(r);
  endfunction

  function automatic logic [7:0] ref_aff(input logic [7:0] b);
    logic [7:0] c = 8'h63;
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = ref_aff(inv);
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic dec);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = dec ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
    return r;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;
  exp_t q[$];

  // Scoreboard on the STAGES=3 instance; sampled mid-cycle, so it sees what the next edge will take.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_qsize", q.size(), 1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
`ifdef PPRM_SBOX_PIPE_TAG_EN
          chk("sb_tag", 32'(out_tag), 32'(e.t));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.d = ref_beat(in_data, in_dec);
        e.t = 4'h0;
`ifdef PPRM_SBOX_PIPE_TAG_EN
        e.t = in_tag;
`endif
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tag(input logic [3:0] t);
`ifdef PPRM_SBOX_PIPE_TAG_EN
    in_tag = t;
`else
    if (t != t) $display("unreachable");
`endif
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 30) begin
      tick();
      n++;
    end
    chk(tag, q.size(), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, bubbles, acc0, bad_ir, bad_inf, seen;
    logic [31:0] held;
    build_tables();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dec = 1'b0; out_ready = 1'b1;
    set_tag(4'h0);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_r1_out_valid", 32'(r1_out_valid), 0);
`ifdef PPRM_SBOX_PIPE_TAG_EN
    chk("rst_out_tag", 32'(out_tag), 0);
`endif
    reset = 1'b0;
    #1 chk("in_ready_after_rst", 32'(in_ready), 1);

    // Single forward beat: latency per instance
    in_valid = 1'b1; in_data = 32'hFF530100; in_dec = 1'b0; set_tag(4'h5);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("lat3_valid_c%0d", k), 32'(out_valid), 32'(k == 3));
      chk($sformatf("lat1_valid_c%0d", k), 32'(r1_out_valid), 32'(k == 1));
      chk($sformatf("lat2_valid_c%0d", k), 32'(r2_out_valid), 32'(k == 2));
      if (k == 1) chk("lat1_data", r1_out_data, 32'h16ED7C63);
      if (k == 2) chk("lat2_data", r2_out_data, 32'h16ED7C63);
      if (k == 3) chk("lat3_data", out_data, 32'h16ED7C63);
      tick();
    end
    chk("inflight_idle", 32'(inflight), 0);

    // Single inverse beat
    in_valid = 1'b1; in_data = 32'h16ED7C63; in_dec = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("dec_valid", 32'(out_valid), 1);
    chk("dec_data", out_data, 32'hFF530100);
    tick();

    // All 256 bytes on lane 0, random other lanes, alternating mode
    stalls = 0; bubbles = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_data[7:0] = 8'(i); in_dec = i[0];
      set_tag(4'($urandom));
      #1;
      if (!in_ready) stalls++;
      if (i >= 3 && !out_valid) bubbles++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_stalls", stalls, 0);
    chk("stream_bubbles", bubbles, 0);
    drain("stream_drain");

    // Backpressure: fill and hold
    out_ready = 1'b0; acc0 = n_acc; held = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_dec = 1'($urandom); set_tag(4'($urandom));
      if (i == 3) held = out_data;
      tick();
    end
    chk("bp_accepted", n_acc - acc0, 3);
    chk("bp_inflight", 32'(inflight), 3);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_stable", out_data, held);
    in_valid = 1'b0; out_ready = 1'b1;
    drain("bp_drain");

    // Full pipe with simultaneous in/out transfers
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_dec = 1'($urandom); set_tag(4'($urandom));
      tick();
    end
    chk("full_inflight", 32'(inflight), 3);
    out_ready = 1'b1; bad_ir = 0; bad_inf = 0;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom; in_dec = 1'($urandom); set_tag(4'($urandom));
      #1;
      if (!in_ready) bad_ir++;
      tick();
      if (inflight != 2'd3) bad_inf++;
    end
    chk("simul_in_ready_drops", bad_ir, 0);
    chk("simul_inflight_changes", bad_inf, 0);
    in_valid = 1'b0;
    drain("simul_drain");

    // Reset with two beats in flight
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_dec = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_inflight", 32'(inflight), 2);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_inflight", 32'(inflight), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_data", out_data, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flushed_beats_seen", seen, 0);

    // Back-to-back tagged beats
    in_valid = 1'b1; in_data = $urandom; in_dec = 1'b0; set_tag(4'h3);
    tick();
    in_data = $urandom; in_dec = 1'b1; set_tag(4'hA);
    tick();
    in_valid = 1'b0;
    drain("tag_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
